// File: rtl/tap_tempo_if.sv
// Tap tempo bus: ms tick and tap inputs, beat/period/status outputs.
// master drives ms_tick/tap; slave (tap_tempo) drives the rest.
interface tap_tempo_if #(
    parameter int MS_WIDTH = 12
);
    logic                ms_tick;
    logic                tap;
    logic                beat;
    logic [MS_WIDTH-1:0] period_ms;
    logic                tapped;
    logic                measuring;

    modport master (
        output ms_tick, tap,
        input  beat, period_ms, tapped, measuring
    );

    modport slave (
        input  ms_tick, tap,
        output beat, period_ms, tapped, measuring
    );
endinterface

// File: rtl/tap_tempo.sv
// Tap tempo: measures ms between taps and regenerates a beat pulse.
// Ports: clk, reset (async, active-low), bus (tap_tempo_if.slave).
// Optional interval averaging with the previous tap: TAP_TEMPO_AVG_EN.
module tap_tempo #(
    parameter int MS_WIDTH   = 12,
    parameter int MIN_MS     = 100,
    parameter int MAX_MS     = 2000,
    parameter int DEFAULT_MS = 500
) (
    input logic        clk,
    input logic        reset,
    tap_tempo_if.slave bus
);
    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [MS_WIDTH-1:0] ONE   = MS_WIDTH'(1);
    localparam logic [MS_WIDTH-1:0] MIN_V = MS_WIDTH'(MIN_MS);
    localparam logic [MS_WIDTH-1:0] MAX_V = MS_WIDTH'(MAX_MS);
    localparam logic [MS_WIDTH-1:0] DEF_V = MS_WIDTH'(DEFAULT_MS);

    state_t              state;
    logic                tap_d;
    logic [MS_WIDTH-1:0] cnt;
    logic [MS_WIDTH-1:0] phase;
    logic [MS_WIDTH-1:0] period;
    logic                tapped_r;
    logic                meas_r;
    logic                beat_r;

    logic                tap_rise;
    logic                tick;
    logic                accept;
    logic                wrap;
    logic [MS_WIDTH-1:0] new_period;

    // A tap edge swallows a coincident tick for both counters.
    assign tap_rise = bus.tap & ~tap_d;
    assign tick     = bus.ms_tick & ~tap_rise;
    assign accept   = (state == MEASURE) & tap_rise
                    & (cnt >= MIN_V) & (cnt <= MAX_V);
    // >= so a shortened period wraps on the next tick.
    assign wrap     = tick & (phase >= period - ONE);

`ifdef TAP_TEMPO_AVG_EN
    logic [MS_WIDTH-1:0] prev_ms;
    logic                prev_valid;
    logic [MS_WIDTH:0]   sum;

    assign sum        = {1'b0, cnt} + {1'b0, prev_ms};
    assign new_period = prev_valid ? MS_WIDTH'(sum >> 1) : cnt;
`else
    assign new_period = cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tap_d      <= 1'b0;
            cnt        <= '0;
            phase      <= '0;
            period     <= DEF_V;
            tapped_r   <= 1'b0;
            meas_r     <= 1'b0;
            beat_r     <= 1'b0;
`ifdef TAP_TEMPO_AVG_EN
            prev_ms    <= '0;
            prev_valid <= 1'b0;
`endif
        end else begin
            tap_d  <= bus.tap;
            // Guard keeps beat from ever lasting two cycles.
            beat_r <= ~beat_r & (accept | wrap);

            if (accept | wrap) begin
                phase <= '0;
            end else if (tick) begin
                phase <= phase + ONE;
            end

            unique case (state)
                IDLE: begin
                    if (tap_rise) begin
                        state  <= MEASURE;
                        meas_r <= 1'b1;
                        cnt    <= '0;
                    end
                end
                MEASURE: begin
                    if (accept) begin
                        period   <= new_period;
                        tapped_r <= 1'b1;
                        cnt      <= '0;
`ifdef TAP_TEMPO_AVG_EN
                        prev_ms    <= cnt;
                        prev_valid <= 1'b1;
`endif
                    end else if (tick) begin
                        cnt <= cnt + ONE;
                        if (cnt == MAX_V) begin
                            state  <= IDLE;
                            meas_r <= 1'b0;
`ifdef TAP_TEMPO_AVG_EN
                            prev_valid <= 1'b0;
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign bus.beat      = beat_r;
    assign bus.period_ms = period;
    assign bus.tapped    = tapped_r;
    assign bus.measuring = meas_r;
endmodule

// File: tb/tb_tap_tempo.sv
// Directed bench for tap_tempo: ms_tick every 4 clk, default parameters.
// Beats are logged by tick number and checked against hand values.
module tb_tap_tempo;
    logic clk;
    logic reset;

    tap_tempo_if #(.MS_WIDTH(12)) bus ();

    tap_tempo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int tick_no;
    int q[$];
    int consec;
    bit prev_beat;
    int exp_a;
    int exp_b;
    int exp_n;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample #1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.beat) begin
            q.push_back(tick_no);
            if (prev_beat) consec++;
        end
        prev_beat = bus.beat;
    endtask

    task automatic tick();
        tick_no++;
        bus.ms_tick = 1'b1;
        step();
        bus.ms_tick = 1'b0;
        step();
        step();
        step();
    endtask

    // Tick, then a one-cycle tap in the idle gap after it.
    task automatic tick_tap();
        tick_no++;
        bus.ms_tick = 1'b1;
        step();
        bus.ms_tick = 1'b0;
        bus.tap = 1'b1;
        step();
        bus.tap = 1'b0;
        step();
        step();
    endtask

    // Tap rising on the same clock as the tick.
    task automatic tick_with_tap();
        tick_no++;
        bus.ms_tick = 1'b1;
        bus.tap = 1'b1;
        step();
        bus.ms_tick = 1'b0;
        bus.tap = 1'b0;
        step();
        step();
        step();
    endtask

    function automatic int qat(input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        tick_no = 0;
        consec = 0;
        prev_beat = 1'b0;
        bus.ms_tick = 1'b0;
        bus.tap = 1'b0;
        reset = 1'b0;

        // Reset state
        step();
        step();
        check("rst_period", int'(bus.period_ms), 500);
        check("rst_tapped", int'(bus.tapped), 0);
        check("rst_meas", int'(bus.measuring), 0);
        check("rst_beat", int'(bus.beat), 0);
        reset = 1'b1;
        step();

        // Free-running default tempo
        q.delete();
        tick_no = 0;
        repeat (1500) tick();
        check("def_nbeats", q.size(), 3);
        check("def_beat0", qat(0), 500);
        check("def_beat2", qat(2), 1500);
        check("def_period", int'(bus.period_ms), 500);
        check("def_tapped", int'(bus.tapped), 0);

        // Two taps 300 ms apart
        q.delete();
        tick_no = 0;
        tick_tap();
        check("t2_meas_on", int'(bus.measuring), 1);
        repeat (299) tick();
        tick_tap();
        check("t2_period", int'(bus.period_ms), 300);
        check("t2_tapped", int'(bus.tapped), 1);
        check("t2_resync", qat(0), 301);
        repeat (600) tick();
        check("t2_nbeats", q.size(), 3);
        check("t2_beat1", qat(1), 601);
        check("t2_beat2", qat(2), 901);
        check("t2_meas", int'(bus.measuring), 1);

        // Tap after 601 ms, bounce at 50, tap at 250
`ifdef TAP_TEMPO_AVG_EN
        exp_a = 450;
        exp_b = 425;
        exp_n = 4;
`else
        exp_a = 601;
        exp_b = 250;
        exp_n = 8;
`endif
        tick_tap();
        check("t3_first", int'(bus.period_ms), exp_a);
        repeat (49) tick();
        tick_tap();
        check("t3_bounce", int'(bus.period_ms), exp_a);
        repeat (199) tick();
        tick_tap();
        check("t3_period", int'(bus.period_ms), exp_b);

        // Timeout after 2001 ticks, beats keep running
        q.delete();
        tick_no = 0;
        repeat (2000) tick();
        check("t4_meas_2000", int'(bus.measuring), 1);
        tick();
        check("t4_meas_2001", int'(bus.measuring), 0);
        check("t4_period", int'(bus.period_ms), exp_b);
        check("t4_nbeats", q.size(), exp_n);

        // Held tap = one event; coincident tap drops its tick
        tick();
        bus.ms_tick = 1'b1;
        tick_no++;
        step();
        bus.ms_tick = 1'b0;
        bus.tap = 1'b1;
        step();
        step();
        step();
        repeat (249) tick();
        bus.tap = 1'b0;
        repeat (151) tick();
        tick_with_tap();
        check("t5_period", int'(bus.period_ms), 400);
        check("t5_meas", int'(bus.measuring), 1);

        // Asynchronous reset mid-measurement
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("t5_arst_period", int'(bus.period_ms), 500);
        check("t5_arst_meas", int'(bus.measuring), 0);
        check("t5_arst_tapped", int'(bus.tapped), 0);
        step();
        reset = 1'b1;
        step();

        // Taps at 0, 400, 600
`ifdef TAP_TEMPO_AVG_EN
        exp_a = 300;
`else
        exp_a = 200;
`endif
        tick_tap();
        repeat (399) tick();
        tick_tap();
        check("t6_first", int'(bus.period_ms), 400);
        repeat (199) tick();
        tick_tap();
        check("t6_second", int'(bus.period_ms), exp_a);
        check("no_consec_beat", consec, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tap_tempo.md
Name: tap_tempo

Overview:
- Consumes the 1 ms enable pulse produced by the fx millisecond tick generator.
- Measures the interval between user button taps in milliseconds.
- Regenerates a free-running beat pulse at the measured period.
- Drives tempo-synced fx (delay time, LFO rate) and the tempo LED.

Parameters:
- MS_WIDTH, 12, width of all millisecond counters and period_ms (max 4095 ms)
- MIN_MS, 100, shortest accepted tap interval in ms; shorter intervals are ignored as bounce or double-tap
- MAX_MS, 2000, longest accepted tap interval in ms; exceeding it aborts the measurement
- DEFAULT_MS, 500, period after reset (120 BPM)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- ms_tick  in  1  one-cycle enable, once per millisecond, synchronous to clk
- tap  in  1  tap button level, active high, already synchronised to clk
- beat  out  1  one-cycle pulse at each beat
- period_ms  out  MS_WIDTH  current beat period in ms
- tapped  out  1  high once any tap interval has been accepted since reset
- measuring  out  1  high while in state MEASURE

Behaviour:
- Reset: clk is the only clock. reset is asynchronous and active-low. While reset=0, state=IDLE, period_ms=DEFAULT_MS, interval counter=0, phase counter=0, beat=0, tapped=0, measuring=0, tap edge register=0. Reset asserted mid-measurement abandons it immediately.
- Tap edge: tap_rise = tap & ~tap_d, where tap_d is tap registered. Only rising edges act. A held button generates one event.
- FSM states are IDLE and MEASURE. measuring = (state==MEASURE), registered.
- IDLE + tap_rise: go to MEASURE, interval counter <= 0.
- MEASURE + ms_tick with no tap_rise: interval counter increments.
  - When the counter reaches MAX_MS+1, go to IDLE (timeout).
  - period_ms is unchanged on timeout.
- MEASURE + tap_rise, using the counter value before any same-cycle increment:
  - Counter < MIN_MS: tap ignored, counting continues, state unchanged.
  - MIN_MS <= counter <= MAX_MS: tap accepted.
    - period_ms <= counter (see optional feature).
    - tapped <= 1.
    - Interval counter <= 0, stay in MEASURE, so consecutive taps keep refining the period.
    - Phase counter <= 0.
    - beat pulses on the next cycle (resync to the tap).
- tap_rise and ms_tick in the same cycle: the tap takes priority. That tick is not counted by either counter.
- Beat generator runs in every state.
  - Phase counter increments on ms_tick.
  - On the ms_tick where phase == period_ms-1: phase <= 0, and beat = 1 on the following cycle for exactly one cycle.
  - Latency from the qualifying ms_tick to beat is 1 clk.
- Period change mid-beat: the new period_ms is used from the next comparison.
  - If phase >= new period_ms-1 when the next ms_tick arrives, that tick wraps phase to 0 and fires beat. No long wraparound.
- Width rules:
  - All counters are MS_WIDTH bits and unsigned.
  - The interval counter saturates and cannot wrap, because the timeout fires at MAX_MS+1.
  - Parameters must satisfy 0 < MIN_MS <= MAX_MS < 2^MS_WIDTH-1 and DEFAULT_MS >= 1.
- beat never asserts in consecutive cycles.

Optional Feature:
- Macro: TAP_TEMPO_AVG_EN.
- Defined:
  - The block keeps prev_ms, the last accepted interval, with a valid flag cleared on reset and on timeout.
  - If the flag is set, an accepted tap sets period_ms <= (counter + prev_ms) >> 1, computed in MS_WIDTH+1 bits and truncating.
  - If the flag is clear, period_ms <= counter.
  - prev_ms <= counter in both cases.
- Undefined: period_ms <= counter directly, and no prev_ms storage is built.

Test Plan (bench drives ms_tick every 4 clk, default parameters):
- Reset released, no taps for 1500 ticks -> beats 500 ticks apart, first beat 1 clk after tick 500; period_ms=500, tapped=0.
- Taps at tick 0 and tick 300 -> period_ms=300, tapped=1, beat 1 clk after the second tap, then beats every 300 ticks; measuring stays 1.
- Taps at tick 0, 50 and 250 -> the 50 ms tap is ignored; period_ms=250.
- Tap at tick 0, then none -> measuring drops after 2001 ticks; period_ms keeps its prior value; beats continue.
- Tap held high for 1000 cycles, and a tap_rise coincident with ms_tick -> a single event, with the tick not counted (taps 400 ticks apart give period_ms=400 exactly); reset pulsed mid-MEASURE returns period_ms=500 and measuring=0 asynchronously.
- With TAP_TEMPO_AVG_EN, taps at ticks 0, 400 and 600 -> period_ms=400, then (200+400)/2=300.
